// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the UART transmit path.
// Line levels are named so the FSM reads in terms of mark and space.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic MARK  = 1'b1;
    localparam logic SPACE = 1'b0;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts 1..CLKS_PER_BIT while enabled and restarts at 1 on clear.
// bit_end is registered and is high on the terminal-count cycle.
module tx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int unsigned    W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [W-1:0]   TERM = W'(CLKS_PER_BIT);
    localparam logic [W-1:0]   ONE  = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         bit_end_q;

    // Count values are for the cycle being entered, so bit_end lines up with cnt_q == TERM.
    always_comb begin
        cnt_d = '0;
        if (enable) begin
            if (clear || (cnt_q == TERM)) begin
                cnt_d = ONE;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q     <= '0;
            bit_end_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_end_q <= (cnt_d == TERM);
        end
    end

    assign bit_end = bit_end_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, LSB-first data, optional even parity, 1 or 2 stop bits.
// All outputs are registered from next-state, so each takes effect in the cycle after the deciding edge.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_done
);

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           idx_q, idx_d;
    logic                 parity_q, parity_d;
    logic                 out_q, out_d;
    logic                 ready_q, done_q, done_d;
    logic                 load;
    logic                 bit_end;

    tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (state_d != state_q),
        .enable  (state_d != IDLE),
        .bit_end (bit_end)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        parity_d = parity_q;
        done_d   = 1'b0;
        load     = 1'b0;
        out_d    = MARK;

        case (state_q)
            IDLE: begin
                if (tx_start) load = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (idx_q == LAST_DATA) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    idx_d   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (idx_q == LAST_STOP) begin
                        done_d = 1'b1;
                        // A request waiting at the end of the last stop bit chains the next frame with no idle gap.
                        if (tx_start) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shift_d  = tx_data;
            parity_d = ^tx_data;
            idx_d    = '0;
            state_d  = START;
        end

        case (state_d)
            START:   out_d = SPACE;
            DATA:    out_d = shift_d[0];
            PARITY:  out_d = parity_d;
            default: out_d = MARK;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            out_q    <= MARK;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
            out_q    <= out_d;
            ready_q  <= (state_d == IDLE);
            done_q   <= done_d;
        end
    end

    assign tx_out   = out_q;
    assign tx_ready = ready_q;
    assign tx_done  = done_q;

endmodule
